// File: rtl/spi_shift_unit.sv
// -----------------------------------------------------------------------------
// spi_shift_unit
//   Serial shift stage that sits behind the SPI serial-clock generator. The
//   generator emits one-cycle strobes one wb_clk_in cycle ahead of each sclk
//   transition. Each strobe can shift one bit of the latched transmit word
//   onto s_out, or sample s_in into the parallel receive word.
//
// Ports
//   wb_clk_in  system clock; all state updates on the rising edge
//   wb_rst_n   asynchronous active-low reset
//   go         start request, only honoured while idle
//   len        bits per transfer (0 encodes MAX_LEN), latched at start
//   lsb        1 = LSB first, 0 = MSB first, latched at start
//   tx_neg     1 = shift out on neg_edge, 0 = on pos_edge, latched at start
//   rx_neg     1 = sample on neg_edge, 0 = on pos_edge, latched at start
//   pos_edge   generator strobe: the next cycle raises sclk
//   neg_edge   generator strobe: the next cycle lowers sclk
//   p_in       transmit word, latched at start
//   s_in       serial receive data
//   s_out      serial transmit data
//   p_out      parallel receive word
//   tip        transfer in progress
//   last       final receive bit is pending
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module spi_shift_unit #(
  parameter  int MAX_LEN = 32,
  localparam int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic               wb_clk_in,
  input  logic               wb_rst_n,
  input  logic               go,
  input  logic [LEN_W-1:0]   len,
  input  logic               lsb,
  input  logic               tx_neg,
  input  logic               rx_neg,
  input  logic               pos_edge,
  input  logic               neg_edge,
  input  logic [MAX_LEN-1:0] p_in,
  input  logic               s_in,
  output logic               s_out,
  output logic [MAX_LEN-1:0] p_out,
  output logic               tip,
  output logic               last,
  output logic               done
);

  // Counters need one extra bit so that they can hold MAX_LEN itself.
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]     n_q,      n_d;
  logic [MAX_LEN-1:0]   txd_q,    txd_d;
  logic                 lsb_q,    lsb_d;
  logic                 tx_neg_q, tx_neg_d;
  logic                 rx_neg_q, rx_neg_d;
  logic                 s_out_q,  s_out_d;
  logic [MAX_LEN-1:0]   p_out_q,  p_out_d;
  logic                 tip_q,    tip_d;
  logic                 done_q,   done_d;

  logic                 tx_edge_s;
  logic                 rx_edge_s;
  logic [LEN_W-1:0]     tx_idx_s;
  logic [LEN_W-1:0]     rx_idx_s;

  // Each direction follows its own latched strobe selection, so both may
  // fire in the same cycle.
  assign tx_edge_s = tx_neg_q ? neg_edge : pos_edge;
  assign rx_edge_s = rx_neg_q ? neg_edge : pos_edge;

  // Counters run N..1; LSB-first walks upward from bit 0, MSB-first walks
  // down from bit N-1. Both results always fit in LEN_W bits.
  assign tx_idx_s = lsb_q ? LEN_W'(n_q - tx_cnt_q) : LEN_W'(tx_cnt_q - CNT_ONE);
  assign rx_idx_s = lsb_q ? LEN_W'(n_q - rx_cnt_q) : LEN_W'(rx_cnt_q - CNT_ONE);

  // Next-state logic for the transfer FSM, the shift counters and the data path.
  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    n_d      = n_q;
    txd_d    = txd_q;
    lsb_d    = lsb_q;
    tx_neg_d = tx_neg_q;
    rx_neg_d = rx_neg_q;
    s_out_d  = s_out_q;
    p_out_d  = p_out_q;
    tip_d    = tip_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Strobes are ignored in the start cycle: the counters are loaded here.
        if (go) begin
          state_d  = ST_ACTIVE;
          txd_d    = p_in;
          lsb_d    = lsb;
          tx_neg_d = tx_neg;
          rx_neg_d = rx_neg;
          n_d      = (len == LEN_W'(0)) ? CNT_MAX : CNT_W'(len);
          tx_cnt_d = (len == LEN_W'(0)) ? CNT_MAX : CNT_W'(len);
          rx_cnt_d = (len == LEN_W'(0)) ? CNT_MAX : CNT_W'(len);
          p_out_d  = '0;
          tip_d    = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        if (tx_edge_s && (tx_cnt_q != CNT_ZERO)) begin
          s_out_d  = txd_q[tx_idx_s];
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_cnt_d = tx_cnt_q;
        end

        // The receive counter reaching zero ends the transfer; done follows
        // in the next cycle together with the return to idle.
        if (rx_edge_s && (rx_cnt_q != CNT_ZERO)) begin
          p_out_d[rx_idx_s] = s_in;
          rx_cnt_d          = rx_cnt_q - CNT_ONE;
          if (rx_cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            tip_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tip_d   = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers with asynchronous reset.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= ST_IDLE;
      tx_cnt_q <= CNT_ZERO;
      rx_cnt_q <= CNT_ZERO;
      n_q      <= CNT_ZERO;
      txd_q    <= '0;
      lsb_q    <= 1'b0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
      s_out_q  <= 1'b0;
      p_out_q  <= '0;
      tip_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      n_q      <= n_d;
      txd_q    <= txd_d;
      lsb_q    <= lsb_d;
      tx_neg_q <= tx_neg_d;
      rx_neg_q <= rx_neg_d;
      s_out_q  <= s_out_d;
      p_out_q  <= p_out_d;
      tip_q    <= tip_d;
      done_q   <= done_d;
    end
  end

  assign s_out = s_out_q;
  assign p_out = p_out_q;
  assign tip   = tip_q;
  assign done  = done_q;
  // Decoded from registered state so control logic sees it a cycle early.
  assign last  = tip_q & (rx_cnt_q == CNT_ONE);

endmodule

// File: tb/tb_spi_shift_unit.sv
module tb_spi_shift_unit;

  logic        clk;
  logic        wb_rst_n;
  logic        go;
  logic [4:0]  len;
  logic        lsb;
  logic        tx_neg;
  logic        rx_neg;
  logic        pos_edge;
  logic        neg_edge;
  logic [31:0] p_in;
  logic        s_in;
  logic        s_out;
  logic [31:0] p_out;
  logic        tip;
  logic        last;
  logic        done;

  logic        loop_en;
  logic        s_in_drv;

  int checks;
  int errors;

  // Expected serial bits, pushed when a transmit strobe is driven.
  logic sb_q[$];

  logic        prev_bit;
  logic [31:0] prev_pout;

  typedef struct {
    logic [4:0]  len;
    logic        lsb;
    logic        tx_neg;
    logic        rx_neg;
    logic        loop;
    logic        s_in_c;
    logic        mid_go;
    logic [31:0] p_in;
    logic [31:0] exp_p;
  } vec_t;

  vec_t tbl[8];

  assign s_in = loop_en ? s_out : s_in_drv;

  spi_shift_unit #(.MAX_LEN(32)) dut (
    .wb_clk_in (clk),
    .wb_rst_n  (wb_rst_n),
    .go        (go),
    .len       (len),
    .lsb       (lsb),
    .tx_neg    (tx_neg),
    .rx_neg    (rx_neg),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .p_in      (p_in),
    .s_in      (s_in),
    .s_out     (s_out),
    .p_out     (p_out),
    .tip       (tip),
    .last      (last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp_v);
    end
  endtask

  function automatic int bits_of(input vec_t v);
    return (v.len == 5'd0) ? 32 : int'(v.len);
  endfunction

  // Issue go (optionally with strobes in the start cycle) and check the
  // one-cycle go->tip latency.
  task automatic start(input vec_t v, input bit strobe_in_t);
    go       = 1'b1;
    len      = v.len;
    lsb      = v.lsb;
    tx_neg   = v.tx_neg;
    rx_neg   = v.rx_neg;
    p_in     = v.p_in;
    loop_en  = v.loop;
    s_in_drv = v.s_in_c;
    pos_edge = strobe_in_t;
    neg_edge = strobe_in_t;
    @(negedge clk);
    go       = 1'b0;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    chk("tip_after_go", 32'(tip), 32'd1);
    chk("done_after_go", 32'(done), 32'd0);
    chk("p_out_cleared", p_out, 32'd0);
    if (strobe_in_t) begin
      chk("s_out_start_strobe", 32'(s_out), 32'(prev_bit));
    end
  endtask

  // One bit: transmit strobe, then receive strobe (same cycle when both
  // directions use the same edge).
  task automatic do_bit(input vec_t v, input int n, input int k);
    logic exp_bit;
    chk("last", 32'(last), 32'(k == n - 1));
    chk("done_mid", 32'(done), 32'd0);
    exp_bit = v.lsb ? v.p_in[k] : v.p_in[n - 1 - k];
    sb_q.push_back(exp_bit);
    pos_edge = !v.tx_neg;
    neg_edge = v.tx_neg;
    if (v.tx_neg == v.rx_neg) begin
      pos_edge = !v.rx_neg;
      neg_edge = v.rx_neg;
    end
    if (v.mid_go && (k == n / 2)) begin
      go   = 1'b1;
      p_in = ~v.p_in;
    end
    @(negedge clk);
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    go       = 1'b0;
    p_in     = v.p_in;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      chk("s_out", 32'(s_out), 32'(sb_q.pop_front()));
    end
    if (v.tx_neg != v.rx_neg) begin
      pos_edge = !v.rx_neg;
      neg_edge = v.rx_neg;
      @(negedge clk);
      pos_edge = 1'b0;
      neg_edge = 1'b0;
    end
  endtask

  // Full transfer; returns at the negedge where done is expected high.
  task automatic run_vec(input vec_t v, input bit strobe_in_t);
    int n;
    n = bits_of(v);
    start(v, strobe_in_t);
    for (int k = 0; k < n; k++) begin
      do_bit(v, n, k);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("tip_end", 32'(tip), 32'd0);
    chk("p_out", p_out, v.exp_p);
    prev_bit  = v.lsb ? v.p_in[n - 1] : v.p_in[0];
    prev_pout = v.exp_p;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wb_rst_n  = 1'b0;
    go        = 1'b0;
    len       = 5'd0;
    lsb       = 1'b0;
    tx_neg    = 1'b0;
    rx_neg    = 1'b0;
    pos_edge  = 1'b0;
    neg_edge  = 1'b0;
    p_in      = 32'd0;
    loop_en   = 1'b0;
    s_in_drv  = 1'b0;
    prev_bit  = 1'b0;
    prev_pout = 32'd0;

    //           len    lsb   txn   rxn   loop  s_in  midgo p_in           exp_p
    tbl[0] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
    tbl[1] = '{5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0001};
    tbl[2] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_003C, 32'h0000_003C};
    tbl[3] = '{5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0009, 32'h0000_000F};
    tbl[4] = '{5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF16, 32'h0000_0016};
    tbl[5] = '{5'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000};
    tbl[6] = '{5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5EAD_BEEF};
    tbl[7] = '{5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_0007};

    repeat (2) @(negedge clk);
    chk("rst_tip", 32'(tip), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_p_out", p_out, 32'd0);
    wb_rst_n = 1'b1;
    @(negedge clk);

    // Table: every transfer after the first starts in the done cycle of
    // the previous one (back-to-back go).
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], 1'b0);
    end
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("tip_idle", 32'(tip), 32'd0);

    // Strobes while idle must not disturb the held outputs.
    pos_edge = 1'b1;
    @(negedge clk);
    pos_edge = 1'b0;
    neg_edge = 1'b1;
    @(negedge clk);
    neg_edge = 1'b0;
    pos_edge = 1'b1;
    neg_edge = 1'b1;
    @(negedge clk);
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    chk("idle_s_out", 32'(s_out), 32'(prev_bit));
    chk("idle_p_out", p_out, prev_pout);
    chk("idle_tip", 32'(tip), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Asynchronous reset after 3 of 8 bits.
    start(tbl[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      do_bit(tbl[0], 8, k);
    end
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("abort_tip", 32'(tip), 32'd0);
    chk("abort_s_out", 32'(s_out), 32'd0);
    chk("abort_p_out", p_out, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_last", 32'(last), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    wb_rst_n  = 1'b1;
    prev_bit  = 1'b0;
    prev_pout = 32'd0;
    @(negedge clk);
    run_vec(tbl[0], 1'b0);

    // Strobes in the start cycle are ignored.
    run_vec(tbl[2], 1'b1);
    @(negedge clk);
    chk("done_final", 32'(done), 32'd0);
    chk("s_out_hold", 32'(s_out), 32'(prev_bit));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
